// File: rtl/spin_controller.sv
// spin_controller: three-slot spin sequencer with a debounced run button and win/pair evaluation.
// Ports:
//   clk                         system clock, rising edge
//   rst_but                     asynchronous active-low reset
//   run_but                     raw active-low push button, asynchronous to clk
//   slot1_num..slot3_num [3:0]  current slot values
//   run1..run3                  slot run enables (1 = spinning)
//   spinning                    run1 | run2 | run3
//   result_valid, win, pair     evaluation of the last spin
//   spin_count [7:0]            spins started, wrapping
//   win_count [7:0]             wins, saturating at 255
module spin_controller #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int STOP_GAP_CYCLES = 25000000
) (
  input  logic       clk,
  input  logic       rst_but,
  input  logic       run_but,
  input  logic [3:0] slot1_num,
  input  logic [3:0] slot2_num,
  input  logic [3:0] slot3_num,
  output logic       run1,
  output logic       run2,
  output logic       run3,
  output logic       spinning,
  output logic       result_valid,
  output logic       win,
  output logic       pair,
  output logic [7:0] spin_count,
  output logic [7:0] win_count
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int GW = $clog2(STOP_GAP_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, SPIN, STOP1, STOP2, EVAL} state_t;
  state_t state;
  logic sync1, sync2, level, press;
  logic [DW-1:0] db_cnt;
  logic [GW-1:0] gap;
  logic db_hit, gap_done, all_eq, any_eq;
  // db_hit marks the cycle the synchronised level has differed for the full debounce window
  assign db_hit = (sync2 != level) && (db_cnt == DW'(DEBOUNCE_CYCLES - 1));
  assign gap_done = gap == GW'(STOP_GAP_CYCLES - 1);
  assign all_eq = (slot1_num == slot2_num) && (slot2_num == slot3_num);
  assign any_eq = (slot1_num == slot2_num) || (slot2_num == slot3_num) || (slot1_num == slot3_num);
  always_ff @(posedge clk or negedge rst_but) begin
    if (!rst_but) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      level  <= 1'b1;
      db_cnt <= '0;
      press  <= 1'b0;
    end else begin
      sync1  <= run_but;
      sync2  <= sync1;
      level  <= db_hit ? sync2 : level;
      db_cnt <= (sync2 == level || db_hit) ? '0 : db_cnt + 1'b1;
      // only an accepted fall to 0 is a press; an accepted release is silent
      press  <= db_hit & ~sync2;
    end
  end
  always_ff @(posedge clk or negedge rst_but) begin
    if (!rst_but) begin
      state        <= IDLE;
      run1         <= 1'b0;
      run2         <= 1'b0;
      run3         <= 1'b0;
      spinning     <= 1'b0;
      result_valid <= 1'b0;
      win          <= 1'b0;
      pair         <= 1'b0;
      spin_count   <= '0;
      win_count    <= '0;
      gap          <= '0;
    end else begin
      case (state)
        IDLE: if (press) begin
          state        <= SPIN;
          run1         <= 1'b1;
          run2         <= 1'b1;
          run3         <= 1'b1;
          spinning     <= 1'b1;
          result_valid <= 1'b0;
          spin_count   <= spin_count + 1'b1;
        end
        SPIN: if (press) begin
          state <= STOP1;
          run1  <= 1'b0;
          gap   <= '0;
        end
        // presses are not looked at while stopping, so an expiry always wins
        STOP1: if (gap_done) begin
          state <= STOP2;
          run2  <= 1'b0;
          gap   <= '0;
        end else gap <= gap + 1'b1;
        STOP2: if (gap_done) begin
          state    <= EVAL;
          run3     <= 1'b0;
          spinning <= 1'b0;
        end else gap <= gap + 1'b1;
        EVAL: begin
          state        <= IDLE;
          result_valid <= 1'b1;
          win          <= all_eq;
          pair         <= any_eq & ~all_eq;
          win_count    <= (all_eq && win_count != 8'hff) ? win_count + 1'b1 : win_count;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spin_controller.sv
// tb_spin_controller: randomized self-checking bench for spin_controller with a spec-level model.
module tb_spin_controller;
  logic clk = 1'b0;
  logic rst_but = 1'b0;
  logic run_but = 1'b1;
  logic [3:0] slot1_num = '0, slot2_num = '0, slot3_num = '0;
  logic run1, run2, run3, spinning, result_valid, win, pair;
  logic [7:0] spin_count, win_count;
  int checks = 0;
  int fails = 0;
  int spins = 0;
  int wins = 0;
  spin_controller #(.DEBOUNCE_CYCLES(4), .STOP_GAP_CYCLES(8)) dut (
    .clk(clk), .rst_but(rst_but), .run_but(run_but),
    .slot1_num(slot1_num), .slot2_num(slot2_num), .slot3_num(slot3_num),
    .run1(run1), .run2(run2), .run3(run3), .spinning(spinning),
    .result_valid(result_valid), .win(win), .pair(pair),
    .spin_count(spin_count), .win_count(win_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic do_start();
    run_but = 1'b0;
    repeat (4) @(negedge clk);
    run_but = 1'b1;
    repeat (8) @(negedge clk);
    spins++;
    chk("start_run1", run1, 1);
    chk("start_run2", run2, 1);
    chk("start_run3", run3, 1);
    chk("start_spinning", spinning, 1);
    chk("start_valid", result_valid, 0);
    chk("start_spin_count", spin_count, spins % 256);
  endtask
  // ig: start of a second 4-cycle button press meant to be ignored (-1 = none)
  task automatic do_spin(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input int ig);
    int t1, t2, t3, tv, n_eq;
    slot1_num = a;
    slot2_num = b;
    slot3_num = c;
    do_start();
    t1 = -1; t2 = -1; t3 = -1; tv = -1;
    for (int i = 0; i < 40; i++) begin
      run_but = (i < 4 || (ig >= 0 && i >= ig && i < ig + 4)) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (!run1 && t1 < 0) t1 = i;
      if (!run2 && t2 < 0) t2 = i;
      if (!run3 && t3 < 0) t3 = i;
      if (result_valid && tv < 0) tv = i;
    end
    run_but = 1'b1;
    n_eq = int'(a == b) + int'(b == c) + int'(a == c);
    if (n_eq == 3) wins++;
    chk("run1_fell", t1 >= 0, 1);
    chk("gap_run1_run2", t2 - t1, 8);
    chk("gap_run2_run3", t3 - t2, 8);
    chk("gap_run3_valid", tv - t3, 1);
    chk("end_valid", result_valid, 1);
    chk("end_win", win, n_eq == 3);
    chk("end_pair", pair, n_eq == 1);
    chk("end_win_count", win_count, wins > 255 ? 255 : wins);
    chk("end_spin_count", spin_count, spins % 256);
    chk("end_running", {run1, run2, run3, spinning}, 0);
  endtask
  initial begin
    int igs[5] = '{-1, 8, 12, 16, 17};
    logic [3:0] v;
    repeat (3) @(negedge clk);
    chk("rst_runs", {run1, run2, run3, spinning}, 0);
    chk("rst_flags", {result_valid, win, pair}, 0);
    chk("rst_spin_count", spin_count, 0);
    chk("rst_win_count", win_count, 0);
    rst_but = 1'b1;
    repeat (3) @(negedge clk);
    run_but = 1'b0;
    repeat (3) @(negedge clk);
    run_but = 1'b1;
    repeat (10) @(negedge clk);
    chk("glitch_run1", run1, 0);
    chk("glitch_spinning", spinning, 0);
    chk("glitch_spin_count", spin_count, 0);
    do_spin(4'd5, 4'd5, 4'd5, -1);
    do_spin(4'd3, 4'd3, 4'd7, 8);
    do_spin(4'd1, 4'd2, 4'd3, 12);
    do_spin(4'd7, 4'd7, 4'd7, 16);
    do_spin(4'd2, 4'd9, 4'd2, 17);
    while (spins < 256)
      do_spin(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), igs[$urandom_range(0, 4)]);
    chk("spin_wrap", spin_count, 0);
    while (wins < 260) begin
      v = 4'($urandom_range(0, 15));
      do_spin(v, v, v, -1);
    end
    chk("win_saturate", win_count, 255);
    do_start();
    for (int i = 0; i < 20 && run1; i++) begin
      run_but = (i < 4) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    run_but = 1'b1;
    chk("reached_stop1", run1, 0);
    repeat (2) @(negedge clk);
    rst_but = 1'b0;
    #1;
    spins = 0;
    wins = 0;
    chk("async_rst_runs", {run1, run2, run3, spinning}, 0);
    chk("async_rst_spin_count", spin_count, 0);
    chk("async_rst_win_count", win_count, 0);
    repeat (3) @(negedge clk);
    rst_but = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", {run1, result_valid}, 0);
    do_spin(4'd9, 4'd9, 4'd9, -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, fails + 1);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/spin_controller.md
SPIN_CONTROLLER -- requirements
Module: spin_controller

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000: consecutive stable clk cycles needed to accept a run_but level change (10 ms at 50 MHz).
REQ-002 Parameter STOP_GAP_CYCLES, default 25000000: clk cycles between successive slot stops (0.5 s at 50 MHz); minimum legal value 1.
REQ-003 clk  input  1  system clock; all state is on the rising edge.
REQ-004 rst_but  input  1  asynchronous, active-low reset; assertion clears all state immediately; deassertion is synchronised externally.
REQ-005 run_but  input  1  raw active-low push button, asynchronous to clk.
REQ-006 slot1_num, slot2_num, slot3_num  input  4 each  current slot values from the slot stage.
REQ-007 run1, run2, run3  output  1 each  slot run enables; 1 = slot spinning.
REQ-008 spinning  output  1  high while any runN is high.
REQ-009 result_valid  output  1  win/pair hold a valid evaluation.
REQ-010 win  output  1  all three latched slot values equal.
REQ-011 pair  output  1  exactly two of the three latched values equal.
REQ-012 spin_count  output  8  number of spins started, wrapping.
REQ-013 win_count  output  8  number of wins, saturating.

Function
REQ-014 run_but SHALL pass through a 2-flop synchroniser before any other use.
REQ-015 The debouncer SHALL hold a debounced level, reset value 1 (released), and a counter that clears on every cycle the synchronised level equals the debounced level.
REQ-016 The debounced level SHALL take the synchronised value when the counter reaches DEBOUNCE_CYCLES; pulses shorter than DEBOUNCE_CYCLES SHALL have no effect.
REQ-017 A debounced 1->0 transition SHALL produce a single-cycle press pulse; release SHALL produce nothing.
REQ-018 The FSM SHALL have states IDLE, SPIN, STOP1, STOP2, EVAL; the reset state is IDLE.
REQ-019 IDLE: on press -> SPIN; next cycle run1=run2=run3=1, result_valid=0, and spin_count increments modulo 256 (255->0).
REQ-020 SPIN: on press -> STOP1; next cycle run1=0; the gap counter loads 0.
REQ-021 STOP1: after STOP_GAP_CYCLES cycles in the state -> STOP2 with run2=0; the gap counter reloads 0.
REQ-022 STOP2: after STOP_GAP_CYCLES cycles in the state -> EVAL with run3=0.
REQ-023 EVAL lasts exactly one cycle: it latches the slot inputs, sets win/pair from them, sets result_valid=1, increments win_count if win (holding at 255), then goes to IDLE.
REQ-024 win and pair SHALL never both be 1; all-different inputs give win=0, pair=0.
REQ-025 Presses in STOP1, STOP2 and EVAL SHALL be ignored and SHALL NOT be queued.
REQ-026 result_valid, win and pair SHALL hold in IDLE until the next press, which clears result_valid (REQ-019).
REQ-027 spinning SHALL equal run1|run2|run3, registered in step with them.
REQ-028 A press pulse coincident with a gap-counter expiry SHALL be ignored; the gap transition SHALL win.

Reset
REQ-029 While rst_but=0, all of the following SHALL be 0: runN, spinning, result_valid, win, pair, spin_count, win_count, the gap counter and the debounce counter. The synchroniser flops and the debounced level SHALL be 1. The state SHALL be IDLE.
REQ-030 Reset asserted mid-spin SHALL stop all slots (runN=0) asynchronously, without waiting for a clk edge.
REQ-031 After reset releases, the first press SHALL need a full DEBOUNCE_CYCLES of stable low.

Verification (DEBOUNCE_CYCLES=4, STOP_GAP_CYCLES=8)
REQ-032 Glitch: run_but low for 3 cycles, then high -> no press pulse, state stays IDLE, runN=0.
REQ-033 Full spin: press, then press again with slots held at 5,5,5 -> run1 falls, run2 falls 8 cycles later, run3 falls 8 cycles after that; one cycle later result_valid=1, win=1, pair=0, spin_count=1, win_count=1.
REQ-034 Pair/none: latched 3,3,7 -> pair=1, win=0; latched 1,2,3 -> win=0, pair=0; win_count unchanged.
REQ-035 Ignored presses: press during STOP1 and during STOP2 -> stop timing unchanged, no restart, spin_count increments only once.
REQ-036 Counter bounds: 256 spins -> spin_count returns to 0; 260 winning spins -> win_count=255.
REQ-037 Reset in STOP1: drive rst_but=0 -> runN, spinning and both counts are 0 before the next clk edge; after release, state is IDLE.
